// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_ctrl_pkg : shared state codes, digit limits and helpers for the panel
// Rev 1.0
// ---------------------------------------------------------------------------
package led_ctrl_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SET_START = 3'd1;
    localparam logic [2:0] ST_SET_STOP  = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_PAUSE     = 3'd4;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [3:0] START_RST = 4'd0;
    localparam logic [3:0] STOP_RST  = 4'd9;

    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d == DIGIT_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_count_ctrl_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_gen : prescaler producing a registered one-cycle tick every TICK_DIV
// cycles while run is high; clr restarts the period. Rev 1.0
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int          CNT_W    = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (run) begin
            if (r_cnt == C_LAST) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/led_count_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_count_ctrl : front-panel controller for the start/stop BCD counter
// Rev 1.0
// ---------------------------------------------------------------------------
module led_count_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int          CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_run,
    input  logic       sw_ud,
    output logic [3:0] start_vl,
    output logic [3:0] stop_vl,
    output logic       ud,
    output logic       cnt_en,
    output logic       cnt_load,
    output logic [2:0] state_o
);

    logic       r_mode_q, r_inc_q, r_run_q;
    logic       w_mode_ev, w_inc_ev, w_run_ev;
    logic [2:0] r_state, w_next;
    logic [3:0] r_start, w_start_nx;
    logic [3:0] r_stop, w_stop_nx;
    logic       r_ud, w_ud_nx;
    logic       r_load, w_load_nx;
    logic       w_enter_run, w_run_stay, w_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q <= 1'b0;
            r_inc_q  <= 1'b0;
            r_run_q  <= 1'b0;
        end else begin
            r_mode_q <= btn_mode;
            r_inc_q  <= btn_inc;
            r_run_q  <= btn_run;
        end
    end

    assign w_mode_ev = btn_mode & ~r_mode_q;
    assign w_run_ev  = btn_run  & ~r_run_q;
    assign w_inc_ev  = btn_inc  & ~r_inc_q;

    // Priority mode > run > inc falls out of the if/else ordering per state.
    always_comb begin
        w_next     = r_state;
        w_start_nx = r_start;
        w_stop_nx  = r_stop;
        w_ud_nx    = r_ud;
        w_load_nx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mode_ev) begin
                    w_next = ST_SET_START;
                end else if (w_run_ev) begin
                    w_next    = ST_RUN;
                    w_load_nx = 1'b1;
                    w_ud_nx   = sw_ud;
                end
            end
            ST_SET_START: begin
                if (w_mode_ev)     w_next     = ST_SET_STOP;
                else if (w_inc_ev) w_start_nx = digit_inc(r_start);
            end
            ST_SET_STOP: begin
                if (w_mode_ev)     w_next    = ST_IDLE;
                else if (w_inc_ev) w_stop_nx = digit_inc(r_stop);
            end
            ST_RUN: begin
                if (w_mode_ev)     w_next = ST_IDLE;
                else if (w_run_ev) w_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (w_mode_ev) begin
                    w_next = ST_IDLE;
                end else if (w_run_ev) begin
                    w_next  = ST_RUN;
                    w_ud_nx = sw_ud;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_start <= START_RST;
            r_stop  <= STOP_RST;
            r_ud    <= 1'b0;
            r_load  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_start <= w_start_nx;
            r_stop  <= w_stop_nx;
            r_ud    <= w_ud_nx;
            r_load  <= w_load_nx;
        end
    end

    // Counting only while RUN persists keeps cnt_en from leaking into the
    // cycle after leaving RUN and keeps it disjoint from the entry load.
    assign w_enter_run = (w_next == ST_RUN) && (r_state != ST_RUN);
    assign w_run_stay  = (w_next == ST_RUN) && (r_state == ST_RUN);

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run_stay),
        .clr   (w_enter_run),
        .tick  (w_tick)
    );

    assign start_vl = r_start;
    assign stop_vl  = r_stop;
    assign ud       = r_ud;
    assign cnt_en   = w_tick;
    assign cnt_load = r_load;
    assign state_o  = r_state;

endmodule
`default_nettype wire
